// File: rtl/ex_mem_stage_pkg.sv
// rtl/ex_mem_stage_pkg.sv - shared constants for the EX/MEM pipeline register
//
// Purpose: status-byte bit positions, control-bit positions and trap cause
//          encodings used by ex_mem_stage and ex_mem_entry.
// Ports:   none (package).
package ex_mem_stage_pkg;

  // Status byte layout: {zero, overflow, carry, negative, invalid_address, div_zero, 2'b00}
  localparam int ST_ZERO     = 7;
  localparam int ST_OVF      = 6;
  localparam int ST_CARRY    = 5;
  localparam int ST_NEG      = 4;
  localparam int ST_INV_ADDR = 3;
  localparam int ST_DIV0     = 2;

  // Control nibble layout: {trap_en, reg_write, mem_write, mem_read}
  localparam int CTRL_W         = 4;
  localparam int CTRL_TRAP_EN   = 3;
  localparam int CTRL_REG_WRITE = 2;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_MEM_READ  = 0;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_OVF  = 2'b01,
    CAUSE_DIV0 = 2'b10,
    CAUSE_BOTH = 2'b11
  } trap_cause_e;

endpackage

// File: rtl/ex_mem_entry.sv
// rtl/ex_mem_entry.sv - one payload slot of the EX/MEM pipeline register
//
// Purpose: holds result/status/store data/rd/ctrl; captures on load. When
//          kill_we is set during a load the architectural side effects
//          (reg_write, mem_write) are stripped from the captured ctrl.
// Ports:   clk, reset_n      clock, async active-low reset (payload -> 0)
//          load, kill_we    capture enable, write-enable suppression
//          d_*              payload in
//          q_*              payload out (registered)
module ex_mem_entry
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int STATUS_W = 8,
  parameter int RD_W     = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                kill_we,
  input  logic [DATA_W-1:0]   d_result,
  input  logic [STATUS_W-1:0] d_status,
  input  logic [DATA_W-1:0]   d_store_data,
  input  logic [RD_W-1:0]     d_rd,
  input  logic [CTRL_W-1:0]   d_ctrl,
  output logic [DATA_W-1:0]   q_result,
  output logic [STATUS_W-1:0] q_status,
  output logic [DATA_W-1:0]   q_store_data,
  output logic [RD_W-1:0]     q_rd,
  output logic [CTRL_W-1:0]   q_ctrl
);

  logic [CTRL_W-1:0] ctrl_masked;

  // mem_read and trap_en deliberately survive the mask.
  always_comb begin
    ctrl_masked = d_ctrl;
    if (kill_we) begin
      ctrl_masked[CTRL_REG_WRITE] = 1'b0;
      ctrl_masked[CTRL_MEM_WRITE] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_result     <= '0;
      q_status     <= '0;
      q_store_data <= '0;
      q_rd         <= '0;
      q_ctrl       <= '0;
    end else if (load) begin
      q_result     <= d_result;
      q_status     <= d_status;
      q_store_data <= d_store_data;
      q_rd         <= d_rd;
      q_ctrl       <= ctrl_masked;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with skid buffer and arithmetic trap
//
// Purpose: two-slot (main + skid) pipeline register between EX and MEM with
//          valid/ready on both sides, overflow/div-zero trap detection at
//          accept, and a sticky OR of accepted status bytes.
// Ports:   clk, reset_n                    clock, async active-low reset
//          ex_valid/ex_ready, ex_*         upstream handshake and payload
//          mem_valid/mem_ready, mem_*      downstream handshake and payload
//          flush                           drop all held entries
//          trap, trap_cause                one-cycle trap pulse, held cause
//          sticky_status, status_clear     accumulated status flags, clear
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int STATUS_W = 8,
  parameter int RD_W     = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [DATA_W-1:0]   ex_alu_result,
  input  logic [STATUS_W-1:0] ex_alu_status,
  input  logic [DATA_W-1:0]   ex_store_data,
  input  logic [RD_W-1:0]     ex_rd,
  input  logic [CTRL_W-1:0]   ex_ctrl,
  input  logic                flush,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [DATA_W-1:0]   mem_alu_result,
  output logic [STATUS_W-1:0] mem_alu_status,
  output logic [DATA_W-1:0]   mem_store_data,
  output logic [RD_W-1:0]     mem_rd,
  output logic [CTRL_W-1:0]   mem_ctrl,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [STATUS_W-1:0] sticky_status,
  input  logic                status_clear
);

  logic main_valid, skid_valid;
  logic accept, live_accept, xfer, trap_hit;
  logic main_load, skid_load, main_kill;
  trap_cause_e cause_q;

  logic [DATA_W-1:0]   skid_result, skid_store_data;
  logic [STATUS_W-1:0] skid_status;
  logic [RD_W-1:0]     skid_rd;
  logic [CTRL_W-1:0]   skid_ctrl;

  logic [DATA_W-1:0]   main_d_result, main_d_store_data;
  logic [STATUS_W-1:0] main_d_status;
  logic [RD_W-1:0]     main_d_rd;
  logic [CTRL_W-1:0]   main_d_ctrl;

  logic [STATUS_W-1:0] acc_status;

  // ex_ready depends only on a flop, so mem_ready never reaches it combinationally.
  assign ex_ready  = !skid_valid;
  assign mem_valid = main_valid;

  assign accept      = ex_valid && ex_ready;
  assign live_accept = accept && !flush;
  assign xfer        = main_valid && mem_ready;
  assign trap_hit    = ex_ctrl[CTRL_TRAP_EN] &&
                       (ex_alu_status[ST_OVF] || ex_alu_status[ST_DIV0]);

  // Main refills from skid when it drains, otherwise from EX when it is free
  // or emptying this cycle. Skid only ever takes EX data while main is stuck.
  // Skid full implies ex_ready low, so the two refill sources never collide.
  assign main_load = !flush &&
                     ((skid_valid && xfer) ||
                      (live_accept && (!main_valid || xfer)));
  assign skid_load = live_accept && main_valid && !xfer;

  // Skid contents were already masked when they entered the skid.
  assign main_kill = !skid_valid && trap_hit;

  always_comb begin
    main_d_result     = ex_alu_result;
    main_d_status     = ex_alu_status;
    main_d_store_data = ex_store_data;
    main_d_rd         = ex_rd;
    main_d_ctrl       = ex_ctrl;
    if (skid_valid) begin
      main_d_result     = skid_result;
      main_d_status     = skid_status;
      main_d_store_data = skid_store_data;
      main_d_rd         = skid_rd;
      main_d_ctrl       = skid_ctrl;
    end
  end

  ex_mem_entry #(.DATA_W(DATA_W), .STATUS_W(STATUS_W), .RD_W(RD_W)) u_main (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (main_load),
    .kill_we      (main_kill),
    .d_result     (main_d_result),
    .d_status     (main_d_status),
    .d_store_data (main_d_store_data),
    .d_rd         (main_d_rd),
    .d_ctrl       (main_d_ctrl),
    .q_result     (mem_alu_result),
    .q_status     (mem_alu_status),
    .q_store_data (mem_store_data),
    .q_rd         (mem_rd),
    .q_ctrl       (mem_ctrl)
  );

  ex_mem_entry #(.DATA_W(DATA_W), .STATUS_W(STATUS_W), .RD_W(RD_W)) u_skid (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (skid_load),
    .kill_we      (trap_hit),
    .d_result     (ex_alu_result),
    .d_status     (ex_alu_status),
    .d_store_data (ex_store_data),
    .d_rd         (ex_rd),
    .d_ctrl       (ex_ctrl),
    .q_result     (skid_result),
    .q_status     (skid_status),
    .q_store_data (skid_store_data),
    .q_rd         (skid_rd),
    .q_ctrl       (skid_ctrl)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (main_load)  main_valid <= 1'b1;
      else if (xfer)  main_valid <= 1'b0;
      if (skid_load)  skid_valid <= 1'b1;
      else if (xfer)  skid_valid <= 1'b0;
    end
  end

  // Reserved low status bits never enter the sticky copy.
  assign acc_status = live_accept ? {ex_alu_status[STATUS_W-1:2], 2'b00} : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trap          <= 1'b0;
      cause_q       <= CAUSE_NONE;
      sticky_status <= '0;
    end else begin
      trap <= live_accept && trap_hit;
      if (live_accept && trap_hit)
        cause_q <= trap_cause_e'({ex_alu_status[ST_DIV0], ex_alu_status[ST_OVF]});
      sticky_status <= (status_clear ? '0 : sticky_status) | acc_status;
    end
  end

  assign trap_cause = cause_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [7:0]  ex_alu_status;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_ctrl;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_alu_result;
  logic [7:0]  mem_alu_status;
  logic [31:0] mem_store_data;
  logic [4:0]  mem_rd;
  logic [3:0]  mem_ctrl;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [7:0]  sticky_status;
  logic        status_clear;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_alu_result  (ex_alu_result),
    .ex_alu_status  (ex_alu_status),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_ctrl        (ex_ctrl),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_alu_result (mem_alu_result),
    .mem_alu_status (mem_alu_status),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_ctrl       (mem_ctrl),
    .trap           (trap),
    .trap_cause     (trap_cause),
    .sticky_status  (sticky_status),
    .status_clear   (status_clear)
  );

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [7:0]  st;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic        mr;
    logic        clr;
    logic        fl;
    logic        e_mv;
    logic        e_rdy;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    logic [3:0]  e_ctrl;
    logic        e_trap;
    logic [1:0]  e_cause;
    logic [7:0]  e_sticky;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [7:0] st,
                       input logic [4:0] rd, input logic [3:0] ctrl, input logic mr,
                       input logic clr, input logic fl);
    ex_valid      = v;
    ex_alu_result = res;
    ex_alu_status = st;
    ex_store_data = res ^ 32'hFFFF_0000;
    ex_rd         = rd;
    ex_ctrl       = ctrl;
    mem_ready     = mr;
    status_clear  = clr;
    flush         = fl;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // v  res  st  rd ctrl mr clr fl | mv rdy res rd ctrl trap cause sticky
    vecs[0]  = '{1, 32'h5,  8'h00, 5'd3,  4'b0100, 1,0,0, 1,1, 32'h5,  5'd3,  4'b0100, 0, 2'b00, 8'h00};
    vecs[1]  = '{0, 32'h0,  8'h00, 5'd0,  4'b0000, 1,0,0, 0,1, 32'h5,  5'd3,  4'b0100, 0, 2'b00, 8'h00};
    vecs[2]  = '{1, 32'h11, 8'h40, 5'd7,  4'b1100, 1,0,0, 1,1, 32'h11, 5'd7,  4'b1000, 1, 2'b01, 8'h40};
    vecs[3]  = '{1, 32'h22, 8'h44, 5'd8,  4'b1110, 1,0,0, 1,1, 32'h22, 5'd8,  4'b1000, 1, 2'b11, 8'h44};
    vecs[4]  = '{1, 32'h33, 8'h40, 5'd9,  4'b0100, 1,0,0, 1,1, 32'h33, 5'd9,  4'b0100, 0, 2'b11, 8'h44};
    vecs[5]  = '{1, 32'h44, 8'h04, 5'd10, 4'b1001, 1,0,0, 1,1, 32'h44, 5'd10, 4'b1001, 1, 2'b10, 8'h44};
    vecs[6]  = '{0, 32'h0,  8'h00, 5'd0,  4'b0000, 1,1,0, 0,1, 32'h44, 5'd10, 4'b1001, 0, 2'b10, 8'h00};
    vecs[7]  = '{1, 32'h55, 8'h80, 5'd1,  4'b0100, 1,0,0, 1,1, 32'h55, 5'd1,  4'b0100, 0, 2'b10, 8'h80};
    vecs[8]  = '{1, 32'h66, 8'h20, 5'd2,  4'b0010, 1,0,0, 1,1, 32'h66, 5'd2,  4'b0010, 0, 2'b10, 8'hA0};
    vecs[9]  = '{1, 32'h77, 8'h04, 5'd4,  4'b0100, 1,1,0, 1,1, 32'h77, 5'd4,  4'b0100, 0, 2'b10, 8'h04};
    vecs[10] = '{1, 32'h88, 8'h83, 5'd5,  4'b0000, 1,0,0, 1,1, 32'h88, 5'd5,  4'b0000, 0, 2'b10, 8'h84};
    vecs[11] = '{0, 32'h0,  8'h00, 5'd0,  4'b0000, 1,0,0, 0,1, 32'h88, 5'd5,  4'b0000, 0, 2'b10, 8'h84};

    reset_n = 1'b0;
    drive(0, 32'h0, 8'h00, 5'd0, 4'b0000, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst mem_valid", 32'(mem_valid), 32'd0);
    check("rst ex_ready", 32'(ex_ready), 32'd1);
    check("rst result", mem_alu_result, 32'h0);
    check("rst ctrl", 32'(mem_ctrl), 32'h0);
    check("rst trap", 32'(trap), 32'd0);
    check("rst cause", 32'(trap_cause), 32'd0);
    check("rst sticky", 32'(sticky_status), 32'h0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].res, vecs[i].st, vecs[i].rd, vecs[i].ctrl,
            vecs[i].mr, vecs[i].clr, vecs[i].fl);
      step();
      check($sformatf("v%0d mem_valid", i), 32'(mem_valid), 32'(vecs[i].e_mv));
      check($sformatf("v%0d ex_ready", i), 32'(ex_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d result", i), mem_alu_result, vecs[i].e_res);
      check($sformatf("v%0d rd", i), 32'(mem_rd), 32'(vecs[i].e_rd));
      check($sformatf("v%0d ctrl", i), 32'(mem_ctrl), 32'(vecs[i].e_ctrl));
      check($sformatf("v%0d trap", i), 32'(trap), 32'(vecs[i].e_trap));
      check($sformatf("v%0d cause", i), 32'(trap_cause), 32'(vecs[i].e_cause));
      check($sformatf("v%0d sticky", i), 32'(sticky_status), 32'(vecs[i].e_sticky));
    end

    // Backpressure: A to main, B to skid, C stalls, then drain in order.
    drive(1, 32'hA1, 8'h00, 5'd11, 4'b0100, 0, 0, 0);
    step();
    check("bp A mem_valid", 32'(mem_valid), 32'd1);
    check("bp A result", mem_alu_result, 32'hA1);
    check("bp A ex_ready", 32'(ex_ready), 32'd1);
    drive(1, 32'hB2, 8'h00, 5'd12, 4'b0100, 0, 0, 0);
    step();
    check("bp B held result", mem_alu_result, 32'hA1);
    check("bp B ex_ready", 32'(ex_ready), 32'd0);
    drive(1, 32'hC3, 8'h00, 5'd13, 4'b0100, 0, 0, 0);
    step();
    check("bp C stall result", mem_alu_result, 32'hA1);
    check("bp C stall store", mem_store_data, 32'hA1 ^ 32'hFFFF_0000);
    check("bp C stall ex_ready", 32'(ex_ready), 32'd0);
    drive(1, 32'hC3, 8'h00, 5'd13, 4'b0100, 1, 0, 0);
    step();
    check("bp drain B result", mem_alu_result, 32'hB2);
    check("bp drain B rd", 32'(mem_rd), 32'd12);
    check("bp drain ex_ready", 32'(ex_ready), 32'd1);
    step();
    check("bp C result", mem_alu_result, 32'hC3);
    check("bp C mem_valid", 32'(mem_valid), 32'd1);
    drive(0, 32'h0, 8'h00, 5'd0, 4'b0000, 1, 0, 0);
    step();
    check("bp empty mem_valid", 32'(mem_valid), 32'd0);

    // Flush with both slots full, then flush swallowing a trapping accept.
    drive(1, 32'hD4, 8'h10, 5'd14, 4'b0100, 0, 0, 0);
    step();
    drive(1, 32'hE5, 8'h10, 5'd15, 4'b0100, 0, 0, 0);
    step();
    check("fl full ex_ready", 32'(ex_ready), 32'd0);
    check("fl full sticky", 32'(sticky_status), 32'h94);
    drive(1, 32'hF6, 8'h44, 5'd16, 4'b1100, 0, 0, 1);
    step();
    check("fl mem_valid", 32'(mem_valid), 32'd0);
    check("fl ex_ready", 32'(ex_ready), 32'd1);
    check("fl trap", 32'(trap), 32'd0);
    check("fl sticky", 32'(sticky_status), 32'h94);
    drive(1, 32'hF7, 8'h44, 5'd17, 4'b1100, 1, 0, 1);
    step();
    check("fl acc mem_valid", 32'(mem_valid), 32'd0);
    check("fl acc trap", 32'(trap), 32'd0);
    check("fl acc cause", 32'(trap_cause), 32'b10);
    check("fl acc sticky", 32'(sticky_status), 32'h94);

    // Asynchronous reset with both slots occupied.
    drive(1, 32'h101, 8'h00, 5'd18, 4'b0100, 0, 0, 0);
    step();
    drive(1, 32'h202, 8'h00, 5'd19, 4'b0100, 0, 0, 0);
    step();
    check("mid full ex_ready", 32'(ex_ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid rst mem_valid", 32'(mem_valid), 32'd0);
    check("mid rst ex_ready", 32'(ex_ready), 32'd1);
    check("mid rst result", mem_alu_result, 32'h0);
    check("mid rst cause", 32'(trap_cause), 32'd0);
    check("mid rst sticky", 32'(sticky_status), 32'h0);
    drive(0, 32'h0, 8'h00, 5'd0, 4'b0000, 1, 0, 0);
    step();
    reset_n = 1'b1;
    step();
    check("post rst mem_valid", 32'(mem_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register between the execute stage (ALU) and the memory stage. It captures the 32-bit ALU result, the 8-bit ALU status byte, the store data and the writeback controls, with a valid/ready handshake on both sides and a one-entry skid buffer so that a memory-side stall never drops an ALU result. It also raises an arithmetic trap on overflow or divide-by-zero, suppresses the faulting instruction's side effects, and keeps a sticky copy of the status flags for the exception logic.

## Interface
- DATA_W, 32, width of the ALU result and of the store data
- STATUS_W, 8, width of the ALU status byte
- RD_W, 5, width of the destination register index
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX holds a valid instruction
- ex_ready  out  1  stage can accept; equals !skid_valid, driven from a register
- ex_alu_result  in  DATA_W  ALU result
- ex_alu_status  in  STATUS_W  {zero, overflow, carry, negative, invalid_address, div_zero, 2'b00}
- ex_store_data  in  DATA_W  rt value for stores
- ex_rd  in  RD_W  destination register
- ex_ctrl  in  4  {trap_en, reg_write, mem_write, mem_read}
- flush  in  1  discard all held entries
- mem_valid  out  1  output entry valid
- mem_ready  in  1  MEM consumes the output entry
- mem_alu_result, mem_alu_status, mem_store_data, mem_rd, mem_ctrl  out  as the ex_ inputs  registered copies
- trap  out  1  one-cycle pulse, registered
- trap_cause  out  2  01 = overflow, 10 = div_zero, 11 = both; held until the next trap
- sticky_status  out  STATUS_W  OR of the status bytes of all accepted entries since the last clear
- status_clear  in  1  clears sticky_status

## Operation
- Accept when ex_valid && ex_ready. Output transfer when mem_valid && mem_ready.
- Storage: a main entry (drives the mem_ outputs) and a skid entry.
- Accept with main empty, or with main transferring in the same cycle: the input goes to main.
- Accept while main is held (mem_valid && !mem_ready): the input goes to skid.
- When main transfers and skid is full: skid moves to main, and the skid is freed.
- Trap check at accept: trap_en && (status[6] || status[2]).
  - On a trap, the accepted entry's reg_write and mem_write are forced to 0; mem_read, the data and the status pass unchanged.
  - trap pulses the cycle after accept and trap_cause updates with it.
- sticky_status next value = (status_clear ? 0 : sticky_status) | (accept ? ex_alu_status : 0). Clear and accept in the same cycle therefore yields the accepted bits only. Bits 1:0 are always 0.
- flush:
  - Clears main_valid and skid_valid next cycle.
  - An accept in the flush cycle is discarded: no trap and no sticky update.
  - flush has priority over all transfers.
- Reset values: all mem_ outputs 0, mem_valid 0, ex_ready 1, trap 0, trap_cause 00, sticky_status 0. Reset mid-transfer discards both entries.

## Timing
- Latency of 1 cycle from accept to mem_valid; full throughput, one entry per cycle, with mem_ready held high.
- ex_ready falls the cycle after skid fills and rises the cycle after skid drains. There is no combinational path from mem_ready to ex_ready.
- Output payload is stable while mem_valid && !mem_ready.
- Simultaneous accept into an empty skid and transfer from main with skid empty: the new entry goes to main, and skid stays empty.

## Structure
- A shared package holds:
  - status bit indices (ZERO=7, OVF=6, CARRY=5, NEG=4, INV_ADDR=3, DIV0=2);
  - ctrl bit indices;
  - trap cause encodings.
- One sub-module, ex_mem_entry: a payload register with load enable and write-enable masking, instantiated for main and for skid.

## Test plan
- Reset, then accept result 0x0000_0005 with rd=3 and mem_ready=1 → mem_valid=1 next cycle with mem_rd=3, then 0 the following cycle.
- Hold mem_ready=0 and send 3 back-to-back entries → main holds the 1st, skid holds the 2nd, ex_ready=0, the 3rd stalls; release mem_ready → all 3 emerge in order with no loss.
- Accept status 0x40 with trap_en=1 and reg_write=1 → trap pulse, trap_cause=01, mem_ctrl reg_write=0; status 0x44 → cause 11.
- Same status with trap_en=0 → no trap, reg_write passes through.
- Accept statuses 0x80 then 0x20 → sticky_status=0xA0; status_clear together with accept of 0x04 → 0x04.
- With both entries full, assert flush together with ex_valid → next cycle mem_valid=0, ex_ready=1, no trap, sticky_status unchanged.
